mole_scheduler: RTL
===================

Name: mole_scheduler

Overview:
- Game-control stage directly downstream of the 8-bit LFSR in the whack-a-mole design.
- Consumes the free-running random byte and picks which hole's mole pops up, then holds it up for a timed window.
- Judges player button presses as hit or miss, keeps score and miss count, and declares game over.
- Its mole index and score feed the display/LED stage.

Parameters:
- NUM_HOLES, 6, number of holes; legal 2..8; the index is 3 bits wide.
- UP_TICKS, 20, number of tick pulses a mole stays up before timing out; legal >= 1.
- GAP_TICKS, 5, number of tick pulses with no mole between spawns; legal >= 1.
- MISS_LIMIT, 3, number of timeouts that ends the game; legal 1..3.
- SCORE_W, 8, width of the score counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle timebase strobe.
- start  in  1  single-cycle start/restart request.
- rnd  in  8  random byte from the LFSR; changes every clk; only bits [2:0] are used.
- btn  in  NUM_HOLES  debounced single-cycle press pulses, one per hole.
- mole_valid  out  1  a mole is currently up.
- mole_idx  out  3  index of the current/last mole.
- mole_oh  out  NUM_HOLES  one-hot of mole_idx, gated by mole_valid.
- score  out  SCORE_W  hit count.
- misses  out  2  timeout count.
- hit_pulse  out  1  one-cycle strobe on a hit.
- miss_pulse  out  1  one-cycle strobe on a timeout.
- game_over  out  1  level; high in OVER.

Behaviour:
- All outputs are registered.
- On reset (rst=0, asynchronous) all outputs are 0, state is IDLE, the counters are 0, and prev_valid is 0.
- States: IDLE, GAP, SPAWN, UP, OVER.
- IDLE: waits for start.
  - When start=1 at an edge: score=0, misses=0, gap_cnt=0, prev_valid=0, go to GAP.
- GAP: mole_valid=0.
  - Each tick increments gap_cnt.
  - At the edge where tick=1 and gap_cnt==GAP_TICKS-1, go to SPAWN.
- SPAWN: each clk, sample rnd[2:0] as cand.
  - Accept cand if cand<NUM_HOLES and (prev_valid==0 or cand!=mole_idx).
  - A 3-bit reject counter counts rejected samples. After 8 consecutive rejects, force cand=(mole_idx+1) mod NUM_HOLES.
  - On accept: load mole_idx=cand, set prev_valid=1, up_cnt=0, clear the reject counter, go to UP. mole_valid=1 from that edge.
  - SPAWN therefore lasts 1..9 clk.
- UP: mole_oh has bit mole_idx set.
  - Hit: btn[mole_idx]=1 at an edge. Then score+=1, saturating at 2^SCORE_W-1. hit_pulse=1 for one cycle, mole_valid=0, gap_cnt=0, go to GAP.
  - Presses on other holes are ignored: no penalty, no state change.
  - Timeout: tick=1 and up_cnt==UP_TICKS-1 with no hit. Then misses+=1, miss_pulse=1 for one cycle, mole_valid=0.
    - If the new misses equals MISS_LIMIT, go to OVER.
    - Otherwise gap_cnt=0 and go to GAP.
  - Otherwise each tick increments up_cnt.
  - A hit and a timeout in the same cycle count as a hit; misses is unchanged.
- OVER: game_over=1; score, misses and mole_idx hold; mole_valid=0.
  - start behaves as in IDLE and clears game_over at the same edge.
- start is ignored in GAP, SPAWN and UP.
- btn and tick are ignored outside the states listed above.
- Pulses never overlap: hit_pulse and miss_pulse are never both 1.
- Reset mid-game returns to IDLE immediately with all outputs 0; there is no partial state.

Test Plan:
- Reset, then start; GAP_TICKS=5; rnd[2:0]=3 held; tick every 4 clk.
  - Expect mole_valid=1 and mole_idx=3, mole_oh=6'b001000, within 1 clk of SPAWN entry, after the 5th tick.
- UP with mole_idx=3; pulse btn=6'b001000.
  - Expect at the next edge: score=1, hit_pulse=1 for exactly one cycle, mole_valid=0.
- rnd[2:0] held at 7, which is out of range for NUM_HOLES=6, with prev mole_idx=3.
  - Expect 8 rejects, then mole_idx=4 on the 9th SPAWN clk.
- rnd[2:0] held at 4 with prev mole_idx=4: the repeat is rejected and the fallback gives 5.
  - Then btn=6'b000001 during UP is ignored, and the mole times out after 20 ticks: misses=1, miss_pulse=1.
- Three consecutive timeouts.
  - Expect game_over=1, misses=3, score held. A start pulse gives game_over=0, score=0, misses=0, state GAP.
- Edge cases:
  - A hit and the final timeout tick on the same edge give score+1 and misses unchanged.
  - Score at 255 plus one hit stays 255.
  - rst=0 asserted mid-UP immediately zeroes all outputs.

Source files
------------

// File: rtl/mole_if.sv
// Bundles the per-cycle game inputs and the registered game outputs of mole_scheduler.
// mole_valid is a level, not a handshake: mole_idx/mole_oh describe a live mole only while it is high.
interface mole_if #(
    parameter int NUM_HOLES = 6,
    parameter int SCORE_W   = 8
);
    logic                 tick;
    logic                 start;
    logic [7:0]           rnd;
    logic [NUM_HOLES-1:0] btn;
    logic                 mole_valid;
    logic [2:0]           mole_idx;
    logic [NUM_HOLES-1:0] mole_oh;
    logic [SCORE_W-1:0]   score;
    logic [1:0]           misses;
    logic                 hit_pulse;
    logic                 miss_pulse;
    logic                 game_over;
    logic [2:0]           state_dbg;

    modport master (
        output tick, start, rnd, btn,
        input  mole_valid, mole_idx, mole_oh, score, misses,
               hit_pulse, miss_pulse, game_over, state_dbg
    );

    modport slave (
        input  tick, start, rnd, btn,
        output mole_valid, mole_idx, mole_oh, score, misses,
               hit_pulse, miss_pulse, game_over, state_dbg
    );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole game control: picks the next hole from the LFSR byte, times the mole,
// judges presses, keeps score/misses and declares game over. All outputs are registered.
module mole_scheduler #(
    parameter int NUM_HOLES  = 6,
    parameter int UP_TICKS   = 20,
    parameter int GAP_TICKS  = 5,
    parameter int MISS_LIMIT = 3,
    parameter int SCORE_W    = 8
) (
    input  logic clk,
    input  logic rst,
    mole_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GAP   = 3'd1,
        S_SPAWN = 3'd2,
        S_UP    = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam int UW = $clog2(UP_TICKS + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);
    localparam logic [UW-1:0] UP_LAST   = UW'(UP_TICKS - 1);
    localparam logic [3:0]    NH        = 4'(NUM_HOLES);
    localparam logic [2:0]    IDX_LAST  = 3'(NUM_HOLES - 1);
    localparam logic [1:0]    MISS_LAST = 2'(MISS_LIMIT);

    state_t               state, state_n;
    logic [GW-1:0]        gap_cnt, gap_cnt_n;
    logic [UW-1:0]        up_cnt, up_cnt_n;
    logic [2:0]           rej_cnt, rej_cnt_n;
    logic                 rej_full, rej_full_n;
    logic                 prev_valid, prev_valid_n;
    logic                 valid_r, valid_n;
    logic [2:0]           idx_r, idx_n;
    logic [NUM_HOLES-1:0] oh_r, oh_n;
    logic [SCORE_W-1:0]   score_r, score_n;
    logic [1:0]           misses_r, misses_n;
    logic                 hit_r, hit_n;
    logic                 miss_r, miss_n;
    logic                 over_r, over_n;

    logic [2:0]           cand;
    logic [2:0]           idx_plus;
    logic                 accept;
    logic                 btn_hit;
    logic [1:0]           misses_inc;
    logic                 unused_rnd;

    assign unused_rnd = ^bus.rnd[7:3];

    function automatic logic [NUM_HOLES-1:0] onehot(input logic [2:0] idx);
        logic [NUM_HOLES-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            oh[i] = (3'(i) == idx);
        end
        return oh;
    endfunction

    // The registered one-hot is only non-zero in UP, so masking btn with it is the hit test.
    assign btn_hit    = |(bus.btn & oh_r);
    assign idx_plus   = (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
    assign misses_inc = misses_r + 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            gap_cnt    <= '0;
            up_cnt     <= '0;
            rej_cnt    <= '0;
            rej_full   <= 1'b0;
            prev_valid <= 1'b0;
            valid_r    <= 1'b0;
            idx_r      <= '0;
            oh_r       <= '0;
            score_r    <= '0;
            misses_r   <= '0;
            hit_r      <= 1'b0;
            miss_r     <= 1'b0;
            over_r     <= 1'b0;
        end else begin
            state      <= state_n;
            gap_cnt    <= gap_cnt_n;
            up_cnt     <= up_cnt_n;
            rej_cnt    <= rej_cnt_n;
            rej_full   <= rej_full_n;
            prev_valid <= prev_valid_n;
            valid_r    <= valid_n;
            idx_r      <= idx_n;
            oh_r       <= oh_n;
            score_r    <= score_n;
            misses_r   <= misses_n;
            hit_r      <= hit_n;
            miss_r     <= miss_n;
            over_r     <= over_n;
        end
    end

    always_comb begin
        state_n      = state;
        gap_cnt_n    = gap_cnt;
        up_cnt_n     = up_cnt;
        rej_cnt_n    = rej_cnt;
        rej_full_n   = rej_full;
        prev_valid_n = prev_valid;
        valid_n      = valid_r;
        idx_n        = idx_r;
        oh_n         = oh_r;
        score_n      = score_r;
        misses_n     = misses_r;
        hit_n        = 1'b0;
        miss_n       = 1'b0;
        over_n       = over_r;
        // After eight straight rejects the successor hole is forced so SPAWN cannot stall.
        cand         = rej_full ? idx_plus : bus.rnd[2:0];
        accept       = ({1'b0, cand} < NH) && (!prev_valid || (cand != idx_r));

        case (state)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    score_n      = '0;
                    misses_n     = '0;
                    gap_cnt_n    = '0;
                    prev_valid_n = 1'b0;
                    over_n       = 1'b0;
                    state_n      = S_GAP;
                end
            end
            S_GAP: begin
                if (bus.tick) begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt_n = '0;
                        state_n   = S_SPAWN;
                    end else begin
                        gap_cnt_n = gap_cnt + GW'(1);
                    end
                end
            end
            S_SPAWN: begin
                if (accept) begin
                    idx_n        = cand;
                    oh_n         = onehot(cand);
                    valid_n      = 1'b1;
                    prev_valid_n = 1'b1;
                    up_cnt_n     = '0;
                    rej_cnt_n    = '0;
                    rej_full_n   = 1'b0;
                    state_n      = S_UP;
                end else begin
                    rej_cnt_n = rej_cnt + 3'd1;
                    if (rej_cnt == 3'd7) begin
                        rej_full_n = 1'b1;
                    end
                end
            end
            S_UP: begin
                // A press wins over a coincident final tick.
                if (btn_hit) begin
                    score_n   = (score_r == '1) ? score_r : score_r + SCORE_W'(1);
                    hit_n     = 1'b1;
                    valid_n   = 1'b0;
                    oh_n      = '0;
                    gap_cnt_n = '0;
                    state_n   = S_GAP;
                end else if (bus.tick) begin
                    if (up_cnt == UP_LAST) begin
                        misses_n = misses_inc;
                        miss_n   = 1'b1;
                        valid_n  = 1'b0;
                        oh_n     = '0;
                        if (misses_inc == MISS_LAST) begin
                            over_n  = 1'b1;
                            state_n = S_OVER;
                        end else begin
                            gap_cnt_n = '0;
                            state_n   = S_GAP;
                        end
                    end else begin
                        up_cnt_n = up_cnt + UW'(1);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.mole_valid = valid_r;
    assign bus.mole_idx   = idx_r;
    assign bus.mole_oh    = oh_r;
    assign bus.score      = score_r;
    assign bus.misses     = misses_r;
    assign bus.hit_pulse  = hit_r;
    assign bus.miss_pulse = miss_r;
    assign bus.game_over  = over_r;
    assign bus.state_dbg  = state;

    a_pulses_exclusive: assert property (@(posedge clk) disable iff (!rst) !(hit_r && miss_r));
    a_oh_matches_valid: assert property (@(posedge clk) disable iff (!rst)
        (valid_r ? (oh_r == onehot(idx_r)) : (oh_r == '0)));

endmodule
